ones_pattern_gen: RTL and testbench

ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

---
 rtl/ones_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_ones_pattern_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: walks every 8-bit word with exactly k ones,
// in ascending order, over a valid/ready stream.
module ones_pattern_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] num_of_ones,
    output logic       busy,
    output logic       pattern_valid,
    input  logic       pattern_ready,
    output logic [7:0] pattern,
    output logic       pattern_last,
    output logic [6:0] pattern_index,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [7:0] pattern_q, pattern_d;
    logic [6:0] index_q, index_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic [2:0] tz;
    logic [7:0] bump;
    logic [7:0] refill;
    logic [7:0] next_word;
    logic [7:0] start_word;
    logic       start_last;
    logic       next_last;

    // Lowest k bits set; k=8 wraps 1<<8 to 0, so 0-1 gives 0xFF.
    function automatic logic [7:0] low_mask(input logic [3:0] k);
        logic [7:0] one;
        one = 8'd1;
        return (one << k) - 8'd1;
    endfunction

    // Largest word with k ones: the low mask pushed to the top.
    function automatic logic [7:0] top_mask(input logic [3:0] k);
        return low_mask(k) << (4'd8 - k);
    endfunction

    // Position of the lowest set bit of the current word.
    always_comb begin
        tz = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pattern_q[i]) tz = 3'(i);
        end
    end

    // Next larger word with equal popcount: ripple the lowest run
    // of ones up by one, then refill the leftover ones at the bottom.
    // The top word is never advanced, so the add cannot carry out.
    always_comb begin
        bump       = pattern_q + (8'd1 << tz);
        refill     = ((pattern_q ^ bump) >> 2) >> tz;
        next_word  = bump | refill;
        next_last  = (next_word == top_mask(k_q));
        start_word = low_mask(num_of_ones);
        start_last = (start_word == top_mask(num_of_ones));
    end

    // Next-state and next-output logic for the IDLE/EMIT/FIN walk.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pattern_d = pattern_q;
        index_d   = index_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_of_ones <= 4'd8) begin
                        state_d   = EMIT;
                        k_d       = num_of_ones;
                        pattern_d = start_word;
                        index_d   = 7'd0;
                        last_d    = start_last;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (valid_q && pattern_ready) begin
                    if (last_q) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pattern_d = next_word;
                        index_d   = index_q + 7'd1;
                        last_d    = next_last;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= 4'd0;
            pattern_q <= 8'd0;
            index_q   <= 7'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pattern_q <= pattern_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign busy          = busy_q;
    assign pattern_valid = valid_q;
    assign pattern       = pattern_q;
    assign pattern_last  = last_q;
    assign pattern_index = index_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: table of k requests checked against a
// scoreboard of ascending popcount-k words, plus reset/hold cases.
module tb_ones_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] num_of_ones = 4'd0;
    logic       pattern_ready = 1'b0;
    logic       busy;
    logic       pattern_valid;
    logic [7:0] pattern;
    logic       pattern_last;
    logic [6:0] pattern_index;
    logic       done;
    logic       error;

    ones_pattern_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_of_ones  (num_of_ones),
        .busy         (busy),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .pattern      (pattern),
        .pattern_last (pattern_last),
        .pattern_index(pattern_index),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] p;
        logic [6:0] idx;
        logic       last;
    } exp_t;

    typedef struct {
        int         k;
        int         len;
        logic [7:0] lastw;
        bit         err;
        int         stall;
        bit         hold;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference sequence: scan 0..255 and keep words with k ones.
    task automatic push_model(input int k);
        int   idx;
        exp_t e;
        idx = 0;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] w;
            w = v[7:0];
            if ($countones(w) == k) begin
                e.p    = w;
                e.idx  = idx[6:0];
                e.last = 1'b0;
                sb.push_back(e);
                idx++;
            end
        end
        if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    task automatic run_req(input vec_t t, output int words,
                           output int errs, output int dones,
                           output logic [7:0] lastw, output int gap,
                           output int bad_idle);
        int         stall_left;
        bit         prev_stall;
        bit         fin;
        int         last_cyc;
        logic [16:0] held;
        exp_t       e;
        words = 0; errs = 0; dones = 0; lastw = 8'h00;
        gap = -1; bad_idle = 0;
        stall_left = 0; prev_stall = 0; fin = 0;
        last_cyc = -100; held = '0;
        @(negedge clk);
        start = 1'b1;
        num_of_ones = t.k[3:0];
        pattern_ready = 1'b0;
        if (t.k <= 8) push_model(t.k);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (t.hold && dones == 0) begin
                start = 1'b1;
                num_of_ones = 4'(t.k + 3);
            end else begin
                start = 1'b0;
            end
            if (error) errs++;
            if (t.k > 8 && (busy || pattern_valid)) bad_idle++;
            if (prev_stall)
                chk("stall_hold",
                    {15'd0, pattern_valid, pattern_last,
                     pattern_index, pattern}, {15'd0, held});
            if (dones > 0 && !done) begin
                chk("busy_after_fin", {31'd0, busy}, 32'd0);
                fin = 1;
            end
            if (done) begin
                dones++;
                gap = cyc - last_cyc;
                start = 1'b0;
            end
            if (t.k > 8 && c >= 4) fin = 1;
            if (stall_left > 0) begin
                pattern_ready = 1'b0;
                stall_left--;
            end else if (t.stall > 0 &&
                         int'($urandom_range(99)) < t.stall) begin
                pattern_ready = 1'b0;
                stall_left = int'($urandom_range(2, 0));
            end else begin
                pattern_ready = 1'b1;
            end
            if (pattern_valid && pattern_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word", {24'd0, pattern}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("pattern", {24'd0, pattern}, {24'd0, e.p});
                    chk("index", {25'd0, pattern_index}, {25'd0, e.idx});
                    chk("last", {31'd0, pattern_last}, {31'd0, e.last});
                end
                words++;
                lastw = pattern;
                last_cyc = cyc;
            end
            prev_stall = pattern_valid && !pattern_ready;
            held = {pattern_valid, pattern_last, pattern_index, pattern};
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        pattern_ready = 1'b0;
    endtask

    vec_t       tbl[10];
    int         words, errs, dones, gap, bad_idle;
    logic [7:0] lastw;
    vec_t       hv;

    initial begin
        tbl[0] = '{2, 28, 8'hC0, 1'b0, 0, 1'b0};
        tbl[1] = '{0, 1, 8'h00, 1'b0, 0, 1'b0};
        tbl[2] = '{8, 1, 8'hFF, 1'b0, 0, 1'b0};
        tbl[3] = '{9, 0, 8'h00, 1'b1, 0, 1'b0};
        tbl[4] = '{1, 8, 8'h80, 1'b0, 0, 1'b0};
        tbl[5] = '{4, 70, 8'hF0, 1'b0, 40, 1'b0};
        tbl[6] = '{5, 56, 8'hF8, 1'b0, 20, 1'b1};
        tbl[7] = '{3, 56, 8'hE0, 1'b0, 10, 1'b0};
        tbl[8] = '{6, 28, 8'hFC, 1'b0, 0, 1'b0};
        tbl[9] = '{7, 8, 8'hFE, 1'b0, 30, 1'b0};

        #12;
        chk("reset_outputs",
            {13'd0, busy, pattern_valid, pattern, pattern_last,
             pattern_index, done, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i], words, errs, dones, lastw, gap, bad_idle);
            chk($sformatf("len_k%0d", tbl[i].k), words, tbl[i].len);
            chk($sformatf("lastw_k%0d", tbl[i].k), {24'd0, lastw},
                {24'd0, tbl[i].lastw});
            chk($sformatf("err_k%0d", tbl[i].k), errs,
                {31'd0, tbl[i].err});
            chk($sformatf("done_k%0d", tbl[i].k), dones,
                {31'd0, !tbl[i].err});
            chk($sformatf("idle_k%0d", tbl[i].k), bad_idle, 0);
            chk($sformatf("sb_left_k%0d", tbl[i].k), sb.size(), 0);
            if (!tbl[i].err)
                chk($sformatf("done_gap_k%0d", tbl[i].k), gap, 1);
            sb.delete();
        end

        // Abort a k=3 walk at index 10 with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        num_of_ones = 4'd3;
        pattern_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (pattern_valid && pattern_index == 7'd10) break;
            @(negedge clk);
        end
        chk("abort_reach_idx10", {25'd0, pattern_index}, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_zero",
            {13'd0, busy, pattern_valid, pattern, pattern_last,
             pattern_index, done, error}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pattern_ready = 1'b0;
        hv = '{3, 56, 8'hE0, 1'b0, 0, 1'b0};
        run_req(hv, words, errs, dones, lastw, gap, bad_idle);
        chk("restart_len_k3", words, 56);
        chk("restart_done_k3", dones, 1);
        sb.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
